shift_pattern_checker: RTL and testbench

- Receive-side monitor for the 8-bit bouncing one-hot shift counter and its direction flag.
- On each valid sample it does three things:
  - decodes the one-hot value to a bit index;
  - predicts the next legal (count, direction) pair and compares the following sample against it;
  - runs a lock state machine with error counting.
- It sits on the consumer side of the shift-counter interface and serves as both a position decoder and a protocol checker.

---
 rtl/shift_pattern_checker.sv | 162 ++++++++++++++++
 tb/tb_shift_pattern_checker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pattern_checker.sv
// rtl/shift_pattern_checker.sv - receive-side decoder and protocol checker for the bouncing one-hot shift counter
// Decodes each valid sample, predicts the next (count, dir) pair, and tracks lock with a saturating error count.
module shift_pattern_checker #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             in_dir,
  output logic [IDX_W-1:0] pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             onehot_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [WIDTH-1:0] exp_count_q, exp_count_d;
  logic             exp_dir_q, exp_dir_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic             pos_valid_q, pos_valid_d;
  logic             seq_err_q, seq_err_d;
  logic             onehot_err_q, onehot_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             is_onehot;
  logic             is_match;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] pred_count;
  logic             pred_dir;
  logic [ERR_W-1:0] err_inc;

  // Clearing the lowest set bit leaves zero only for a single-bit value.
  always_comb begin
    is_onehot = (in_count != '0) && ((in_count & (in_count - WIDTH'(1))) == '0);
    is_match  = (in_count == exp_count_q) && (in_dir == exp_dir_q);
    err_inc   = (&err_count_q) ? err_count_q : err_count_q + ERR_W'(1);
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_count[i]) idx = IDX_W'(i);
    end
  end

  // Direction flips when the set bit sits at the end it is heading toward.
  always_comb begin
    pred_count = in_count;
    pred_dir   = in_dir;
    if (!in_dir) begin
      if (in_count[WIDTH-1]) begin
        pred_count = {in_count[0], in_count[WIDTH-1:1]};
        pred_dir   = 1'b1;
      end else begin
        pred_count = {in_count[WIDTH-2:0], in_count[WIDTH-1]};
      end
    end else begin
      if (in_count[0]) begin
        pred_count = {in_count[WIDTH-2:0], in_count[WIDTH-1]};
        pred_dir   = 1'b0;
      end else begin
        pred_count = {in_count[0], in_count[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    match_d      = match_q;
    exp_count_d  = exp_count_q;
    exp_dir_d    = exp_dir_q;
    pos_d        = pos_q;
    err_count_d  = err_count_q;
    pos_valid_d  = 1'b0;
    seq_err_d    = 1'b0;
    onehot_err_d = 1'b0;
    if (in_valid) begin
      if (!is_onehot) begin
        onehot_err_d = 1'b1;
        if (state_q == ST_LOCKED) err_count_d = err_inc;
        state_d = ST_HUNT;
        match_d = '0;
      end else begin
        pos_d       = idx;
        pos_valid_d = 1'b1;
        exp_count_d = pred_count;
        exp_dir_d   = pred_dir;
        case (state_q)
          ST_HUNT: begin
            state_d = ST_TRACK;
            match_d = '0;
          end
          ST_TRACK: begin
            if (is_match) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == 4'(LOCK_COUNT)) state_d = ST_LOCKED;
            end else begin
              match_d = '0;
            end
          end
          ST_LOCKED: begin
            if (!is_match) begin
              seq_err_d   = 1'b1;
              err_count_d = err_inc;
              state_d     = ST_TRACK;
              match_d     = '0;
            end
          end
          default: begin
            state_d = ST_HUNT;
            match_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      match_q      <= '0;
      exp_count_q  <= '0;
      exp_dir_q    <= 1'b0;
      pos_q        <= '0;
      pos_valid_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      onehot_err_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      match_q      <= match_d;
      exp_count_q  <= exp_count_d;
      exp_dir_q    <= exp_dir_d;
      pos_q        <= pos_d;
      pos_valid_q  <= pos_valid_d;
      seq_err_q    <= seq_err_d;
      onehot_err_q <= onehot_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign pos        = pos_q;
  assign pos_valid  = pos_valid_q;
  assign locked     = (state_q == ST_LOCKED);
  assign seq_err    = seq_err_q;
  assign onehot_err = onehot_err_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_shift_pattern_checker.sv
// tb/tb_shift_pattern_checker.sv - scoreboard bench for shift_pattern_checker
// Expected responses come from an index-arithmetic reference model; a monitor pops them per DUT output pulse.
module tb_shift_pattern_checker;

  localparam int WIDTH      = 8;
  localparam int IDX_W      = 3;
  localparam int LOCK_COUNT = 3;
  localparam int ERR_W      = 2;
  localparam int ERR_MAX    = (1 << ERR_W) - 1;
  localparam int M_HUNT     = 0;
  localparam int M_TRACK    = 1;
  localparam int M_LOCKED   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_count;
  logic             in_dir;
  logic [IDX_W-1:0] pos;
  logic             pos_valid;
  logic             locked;
  logic             seq_err;
  logic             onehot_err;
  logic [ERR_W-1:0] err_count;

  shift_pattern_checker #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_count(in_count), .in_dir(in_dir),
    .pos(pos), .pos_valid(pos_valid), .locked(locked), .seq_err(seq_err),
    .onehot_err(onehot_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pos;
    bit pv;
    bit lk;
    bit se;
    bit oe;
    int ec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int m_state, m_match, m_exp_p, m_exp_d, m_pos, m_err;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_HUNT; m_match = 0; m_exp_p = 0; m_exp_d = 0; m_pos = 0; m_err = 0;
  endtask

  // Reference: position/direction are plain integers bouncing between 0 and WIDTH-1.
  task automatic model_apply(logic [WIDTH-1:0] c, logic d);
    exp_t e;
    int   p;
    e.se = 0;
    e.oe = 0;
    if ($countones(c) != 1) begin
      e.oe = 1;
      if (m_state == M_LOCKED && m_err < ERR_MAX) m_err++;
      m_state = M_HUNT;
      m_match = 0;
    end else begin
      p = $clog2(c);
      m_pos = p;
      if (m_state == M_HUNT) begin
        m_state = M_TRACK;
        m_match = 0;
      end else if (p == m_exp_p && int'(d) == m_exp_d) begin
        if (m_state == M_TRACK) begin
          m_match++;
          if (m_match == LOCK_COUNT) m_state = M_LOCKED;
        end
      end else begin
        if (m_state == M_LOCKED) begin
          e.se = 1;
          if (m_err < ERR_MAX) m_err++;
        end
        m_state = M_TRACK;
        m_match = 0;
      end
      if (d == 1'b0) begin
        if (p == WIDTH - 1) begin m_exp_p = p - 1; m_exp_d = 1; end
        else begin m_exp_p = p + 1; m_exp_d = 0; end
      end else begin
        if (p == 0) begin m_exp_p = 1; m_exp_d = 0; end
        else begin m_exp_p = p - 1; m_exp_d = 1; end
      end
    end
    e.pos = m_pos;
    e.pv  = !e.oe;
    e.lk  = (m_state == M_LOCKED);
    e.ec  = m_err;
    q.push_back(e);
  endtask

  // Called aligned one time unit after a rising edge; returns in the same alignment.
  task automatic send(logic [WIDTH-1:0] c, logic d, int gap);
    in_valid = 1'b1;
    in_count = c;
    in_dir   = d;
    model_apply(c, d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_count = $urandom;
    in_dir   = $urandom;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_next(int gap);
    logic [WIDTH-1:0] c;
    c = '0;
    c[m_exp_p] = 1'b1;
    send(c, m_exp_d[0], gap);
  endtask

  task automatic send_mismatch(int gap);
    logic [WIDTH-1:0] c;
    c = '0;
    c[(m_exp_p + 2) % WIDTH] = 1'b1;
    send(c, m_exp_d[0], gap);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_pos"}, int'(pos), 0);
    chk({tag, "_pos_valid"}, int'(pos_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_onehot_err"}, int'(onehot_err), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  task automatic reset_with_valid();
    logic [WIDTH-1:0] c;
    c = '0;
    c[$urandom_range(0, WIDTH - 1)] = 1'b1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_count = c;
    in_dir   = $urandom;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset_over_valid");
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pos_valid || onehot_err) begin
      chk("sb_entry_available", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pos", int'(pos), e.pos);
        chk("pos_valid", int'(pos_valid), int'(e.pv));
        chk("locked", int'(locked), int'(e.lk));
        chk("seq_err", int'(seq_err), int'(e.se));
        chk("onehot_err", int'(onehot_err), int'(e.oe));
        chk("err_count", int'(err_count), e.ec);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r, gap, guard;
    logic [WIDTH-1:0] v;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_count = '0;
    in_dir   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    // Lock up on 01,02,04,08, then ride through both turnarounds.
    repeat (4) send_next(0);
    chk("locked_after_08", int'(locked), 1);
    repeat (12) send_next(0);
    guard = 0;
    while (!(m_exp_p == 4 && m_exp_d == 1) && guard < 20) begin
      send_next(0);
      guard++;
    end
    chk("reach_10_dir1", int'(guard < 20), 1);
    send(8'h04, 1'b1, 0);
    repeat (3) send_next(0);
    send(8'h00, 1'b0, 0);
    send(8'h18, 1'b0, 0);

    // Direction-only mismatch while locked, then saturation with relocks in between.
    repeat (4) send_next(0);
    send(8'h01 << m_exp_p, ~m_exp_d[0], 0);
    for (int k = 0; k < 5; k++) begin
      repeat (3) send_next(0);
      send_mismatch(0);
    end
    repeat (4) send_next($urandom_range(0, 4));
    reset_with_valid();

    for (int n = 0; n < 1500; n++) begin
      r   = $urandom_range(0, 99);
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      if (r < 80) begin
        send_next(gap);
      end else if (r < 86) begin
        v = '0;
        v[$urandom_range(0, WIDTH - 1)] = 1'b1;
        send(v, $urandom, gap);
      end else if (r < 90) begin
        v = '0;
        v[m_exp_p] = 1'b1;
        send(v, ~m_exp_d[0], gap);
      end else if (r < 97) begin
        v = $urandom;
        if ($urandom_range(0, 2) == 0) v = '0;
        else v[$urandom_range(0, WIDTH - 1)] = 1'b1;
        if ($countones(v) == 1) v = v | (v << 1) | (v >> 1);
        send(v, $urandom, gap);
      end else begin
        reset_with_valid();
      end
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
